// File: rtl/alu_core.sv
// Multi-cycle two-operand ALU: opcode and A on the start cycle, B on the next,
// then a registered result/overflow with a single-cycle done pulse.
module alu_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  opcode_valid,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GET_B = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [2:0]                    op_q, op_d;
  logic signed [DATA_WIDTH-1:0]  a_q, a_d;
  logic signed [DATA_WIDTH-1:0]  b_q, b_d;
  logic signed [DATA_WIDTH-1:0]  result_q, result_d;
  logic                          ovf_q, ovf_d;
  logic                          done_q, done_d;
  logic [DATA_WIDTH:0]           eval;

  // Returns {overflow, result}; overflow is only meaningful for ADD/SUB/SHL.
  function automatic logic [DATA_WIDTH:0] alu_eval(
    input logic [2:0]                   op,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH-1:0] r;
    logic                         v;
    r = '0;
    v = 1'b0;
    case (op)
      3'b000: begin
        r = a + b;
        v = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (r[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      3'b001: begin
        r = a - b;
        v = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (r[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ~a;
      3'b110: begin
        r = {a[DATA_WIDTH-2:0], 1'b0};
        v = a[DATA_WIDTH-1];
      end
      default: begin
        r = '0;
        v = 1'b0;
      end
    endcase
    return {v, r};
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    eval     = alu_eval(op_q, a_q, b_q);
    case (state_q)
      // A start is accepted from DONE as well, giving one op every 3 cycles.
      S_IDLE, S_DONE: begin
        if (opcode_valid) begin
          state_d = S_GET_B;
          op_d    = opcode;
          a_d     = $signed(data);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GET_B: begin
        b_d     = $signed(data);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = $signed(eval[DATA_WIDTH-1:0]);
        ovf_d    = eval[DATA_WIDTH];
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign result   = $unsigned(result_q);
  assign overflow = ovf_q;
  assign done     = done_q;
  assign busy     = (state_q == S_GET_B) || (state_q == S_EXEC);

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed cases with literal expectations
// plus randomized traffic checked every cycle against a cycle-indexed model.
module tb_alu_core;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         opcode_valid = 1'b0;
  logic [2:0]   opcode = 3'd0;
  logic [W-1:0] data = '0;
  logic [W-1:0] result;
  logic         overflow;
  logic         done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_core #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode_valid (opcode_valid),
    .opcode       (opcode),
    .data         (data),
    .result       (result),
    .overflow     (overflow),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic on the operation definitions, returns {ovf, res}.
  function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, s, ua;
    logic [7:0] r;
    logic v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    r = 8'h00;
    v = 1'b0;
    s = 0;
    case (op)
      3'd0: begin s = sa + sb; r = s[7:0]; v = (s > 127) || (s < -128); end
      3'd1: begin s = sa - sb; r = s[7:0]; v = (s > 127) || (s < -128); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 8'hFF - a;
      3'd6: begin s = (ua * 2) % 256; r = s[7:0]; v = (ua >= 128); end
      default: r = 8'h00;
    endcase
    return {v, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted start at edge n yields B at n+1 and a result at n+2.
  int         cyc = 0;
  int         start_cyc = -10;
  logic [2:0] m_op = 3'd0;
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;
  logic [7:0] exp_res = 8'h00;
  logic       exp_ovf = 1'b0;
  logic       exp_done = 1'b0;
  logic       exp_busy = 1'b0;
  logic       model_on = 1'b0;
  logic [8:0] rv;

  always @(posedge clk) begin
    if (reset) begin
      start_cyc = -10;
      exp_res   = 8'h00;
      exp_ovf   = 1'b0;
      exp_done  = 1'b0;
      exp_busy  = 1'b0;
      model_on  = 1'b1;
    end else begin
      exp_done = 1'b0;
      if (start_cyc >= 0 && cyc == start_cyc + 1) m_b = data;
      if (start_cyc >= 0 && cyc == start_cyc + 2) begin
        rv       = ref_op(m_op, m_a, m_b);
        exp_res  = rv[7:0];
        exp_ovf  = rv[8];
        exp_done = 1'b1;
      end
      if (opcode_valid && (start_cyc < 0 || cyc >= start_cyc + 3)) begin
        start_cyc = cyc;
        m_op      = opcode;
        m_a       = data;
      end
      exp_busy = (start_cyc >= 0) && (cyc == start_cyc || cyc == start_cyc + 1);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("done",     {31'd0, done},     {31'd0, exp_done});
      chk("busy",     {31'd0, busy},     {31'd0, exp_busy});
      chk("result",   {24'd0, result},   {24'd0, exp_res});
      chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    end
  end

  task automatic drive(input logic r, input logic v, input logic [2:0] op, input logic [7:0] d);
    @(negedge clk);
    reset        = r;
    opcode_valid = v;
    opcode       = op;
    data         = d;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic eo);
    drive(1'b0, 1'b1, op, a);
    settle();
    chk({name, " busy@k"}, {31'd0, busy}, 32'd1);
    chk({name, " done@k"}, {31'd0, done}, 32'd0);
    drive(1'b0, 1'b0, 3'($urandom), b);
    settle();
    chk({name, " busy@k+1"}, {31'd0, busy}, 32'd1);
    chk({name, " done@k+1"}, {31'd0, done}, 32'd0);
    drive(1'b0, 1'b0, 3'($urandom), 8'($urandom));
    settle();
    chk({name, " done@k+2"}, {31'd0, done}, 32'd1);
    chk({name, " busy@k+2"}, {31'd0, busy}, 32'd0);
    chk({name, " result"},   {24'd0, result}, {24'd0, er});
    chk({name, " overflow"}, {31'd0, overflow}, {31'd0, eo});
  endtask

  initial begin
    drive(1'b1, 1'b0, 3'd0, 8'h00);
    repeat (5) drive(1'b0, 1'($urandom), 3'($urandom), 8'($urandom));

    // Reset from an arbitrary state, held for two cycles
    drive(1'b1, 1'b1, 3'($urandom), 8'($urandom));
    settle();
    chk("reset result",   {24'd0, result}, 32'h00);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    chk("reset done",     {31'd0, done}, 32'd0);
    chk("reset busy",     {31'd0, busy}, 32'd0);
    drive(1'b1, 1'b0, 3'd0, 8'h00);
    drive(1'b0, 1'b0, 3'd0, 8'h00);

    run_op("ADD ovf",  3'd0, 8'h7F, 8'h01, 8'h80, 1'b1);
    run_op("ADD",      3'd0, 8'h10, 8'h20, 8'h30, 1'b0);
    run_op("SUB ovf",  3'd1, 8'h80, 8'h01, 8'h7F, 1'b1);
    run_op("SHL",      3'd6, 8'h81, 8'h00, 8'h02, 1'b1);
    run_op("RSVD",     3'd7, 8'hAB, 8'hCD, 8'h00, 1'b0);
    run_op("NOT",      3'd5, 8'h3C, 8'hFF, 8'hC3, 1'b0);
    // Back-to-back: second start lands in the DONE cycle of the first
    run_op("AND b2b",  3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0);
    run_op("OR b2b",   3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    drive(1'b0, 1'b0, 3'd0, 8'h00);

    // Strobe held high: only the IDLE and DONE cycles start operations
    drive(1'b0, 1'b1, 3'd4, 8'hAA);
    drive(1'b0, 1'b1, 3'd1, 8'h55);
    drive(1'b0, 1'b1, 3'd3, 8'h77);
    settle();
    chk("XOR held done",   {31'd0, done}, 32'd1);
    chk("XOR held result", {24'd0, result}, 32'hFF);
    drive(1'b0, 1'b1, 3'd2, 8'h0F);
    settle();
    chk("held k+3 done", {31'd0, done}, 32'd0);
    chk("held k+3 busy", {31'd0, busy}, 32'd1);
    drive(1'b0, 1'b0, 3'd0, 8'hFF);
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    settle();
    chk("2nd op done",   {31'd0, done}, 32'd1);
    chk("2nd op result", {24'd0, result}, 32'h0F);

    // Reset while the operation sits in EXEC
    drive(1'b0, 1'b1, 3'd0, 8'h10);
    drive(1'b0, 1'b0, 3'd0, 8'h20);
    drive(1'b1, 1'b0, 3'd0, 8'h00);
    settle();
    chk("abort done",   {31'd0, done}, 32'd0);
    chk("abort result", {24'd0, result}, 32'h00);
    chk("abort busy",   {31'd0, busy}, 32'd0);
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    settle();
    chk("abort no done", {31'd0, done}, 32'd0);
    run_op("after abort", 3'd0, 8'h10, 8'h20, 8'h30, 1'b0);

    // Randomized traffic, checked by the per-cycle compare process
    repeat (2000) drive(1'(($urandom % 50) == 0), 1'($urandom), 3'($urandom), 8'($urandom));
    repeat (4) drive(1'b0, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
